// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared state encoding and default constants for the
//            instruction/data memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Default widths and limits; the arbiter parameters take these as defaults
  localparam int MEM_ADDR_W     = 32;
  localparam int MEM_DATA_W     = 64;
  localparam int MEM_TIMEOUT    = 255;
  localparam int ARB_STREAK_MAX = 3;

  // Fixed internal widths
  localparam int WAIT_W    = 9;   // wait-state counter
  localparam int STREAK_W  = 2;   // consecutive data-grant counter
  localparam int IF_DATA_W = 32;  // instruction word

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_DM = 2'd1,
    GRANT_IF = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Bundle of the fetch port, data port and memory port seen by the
//            arbiter. 'slave' is the arbiter's view, 'master' the view of
//            the surrounding core and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  // Fetch port
  logic                 if_req;
  logic [ADDR_W-1:0]    if_addr;
  logic [IF_DATA_W-1:0] if_rdata;
  logic                 if_ack;
  logic                 if_stall;

  // Data port
  logic                 dm_req;
  logic                 dm_we;
  logic                 dm_byte;
  logic                 dm_double;
  logic [ADDR_W-1:0]    dm_addr;
  logic [DATA_W-1:0]    dm_wdata;
  logic [DATA_W-1:0]    dm_rdata;
  logic                 dm_ack;
  logic                 dm_stall;

  // Single-ported memory
  logic                 mem_req;
  logic                 mem_we;
  logic                 mem_byte;
  logic                 mem_double;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 mem_ready;

  // Status
  logic                 err_timeout;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_byte, dm_double, dm_addr, dm_wdata,
    input  mem_rdata, mem_ready,
    output if_rdata, if_ack, if_stall,
    output dm_rdata, dm_ack, dm_stall,
    output mem_req, mem_we, mem_byte, mem_double, mem_addr, mem_wdata,
    output err_timeout
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_byte, dm_double, dm_addr, dm_wdata,
    output mem_rdata, mem_ready,
    input  if_rdata, if_ack, if_stall,
    input  dm_rdata, dm_ack, dm_stall,
    input  mem_req, mem_we, mem_byte, mem_double, mem_addr, mem_wdata,
    input  err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_priority_sel.sv
`default_nettype none
// ============================================================================
// Module   : arb_priority_sel
// Brief    : Chooses between the fetch and data requester. Data normally
//            wins; after STREAK_MAX consecutive data grants taken while a
//            fetch was waiting, the fetch is served once.
// Revision : 1.0 - initial release
// ============================================================================
module arb_priority_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STREAK_MAX = ARB_STREAK_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic dm_req,
  input  logic take,      // a grant is being taken this cycle
  output logic grant_dm,
  output logic grant_if
);

  localparam logic [STREAK_W-1:0] c_streak_max = STREAK_W'(STREAK_MAX);

  logic [STREAK_W-1:0] r_streak;
  logic                w_fetch_turn;

  // The fetch is owed a slot only if it is actually waiting
  assign w_fetch_turn = if_req && (r_streak == c_streak_max);
  assign grant_dm     = dm_req && !w_fetch_turn;
  assign grant_if     = if_req && !grant_dm;

  // Track how many data grants in a row have starved a pending fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (take) begin
      if (grant_if) begin
        r_streak <= '0;
      end else if (grant_dm) begin
        if (if_req) begin
          if (r_streak != '1) begin
            r_streak <= r_streak + 1'b1;
          end
        end else begin
          r_streak <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-ported memory between an instruction fetch
//            port and a data port. Each access runs IDLE -> GRANT -> DONE;
//            a stalled memory is abandoned after TIMEOUT wait states with
//            zero read data and a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int TIMEOUT    = MEM_TIMEOUT,
  parameter int STREAK_MAX = ARB_STREAK_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] c_timeout = WAIT_W'(TIMEOUT);

  arb_state_t           r_state;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic                 r_mem_byte;
  logic                 r_mem_double;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic [IF_DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0]    r_dm_rdata;
  logic                 r_if_ack;
  logic                 r_dm_ack;
  logic                 r_err_timeout;
  logic [WAIT_W-1:0]    r_wait;

  logic                 w_grant_dm;
  logic                 w_grant_if;
  logic                 w_take;
  logic [WAIT_W-1:0]    w_wait_inc;
  logic                 w_wait_expired;

  // Requests are only looked at in IDLE, so DONE never re-grants
  assign w_take = (r_state == IDLE) && (w_grant_dm || w_grant_if);

  // This wait cycle is the one that brings the count up to the limit
  assign w_wait_inc     = r_wait + 1'b1;
  assign w_wait_expired = (w_wait_inc == c_timeout);

  arb_priority_sel #(
    .STREAK_MAX (STREAK_MAX)
  ) u_arb_priority_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (bus.if_req),
    .dm_req   (bus.dm_req),
    .take     (w_take),
    .grant_dm (w_grant_dm),
    .grant_if (w_grant_if)
  );

  // Access sequencer: grant, wait for memory or timeout, pulse ack, return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_byte    <= 1'b0;
      r_mem_double  <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_if_rdata    <= '0;
      r_dm_rdata    <= '0;
      r_if_ack      <= 1'b0;
      r_dm_ack      <= 1'b0;
      r_err_timeout <= 1'b0;
      r_wait        <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_mem_req <= 1'b1;
            r_wait    <= '0;
            if (w_grant_dm) begin
              r_state      <= GRANT_DM;
              r_mem_we     <= bus.dm_we;
              r_mem_byte   <= bus.dm_byte;
              r_mem_double <= bus.dm_double;
              r_mem_addr   <= bus.dm_addr;
              r_mem_wdata  <= bus.dm_wdata;
            end else if (w_grant_if) begin
              // Fetches are always plain word reads
              r_state      <= GRANT_IF;
              r_mem_we     <= 1'b0;
              r_mem_byte   <= 1'b0;
              r_mem_double <= 1'b0;
              r_mem_addr   <= bus.if_addr;
              r_mem_wdata  <= '0;
            end
          end
        end

        GRANT_DM, GRANT_IF: begin
          if (bus.mem_ready || w_wait_expired) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            if (!bus.mem_ready) begin
              r_err_timeout <= 1'b1;
            end
            if (r_state == GRANT_IF) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= bus.mem_ready ? bus.mem_rdata[IF_DATA_W-1:0] : '0;
            end else begin
              r_dm_ack <= 1'b1;
              // Stores leave the last load data in place
              if (!r_mem_we) begin
                r_dm_rdata <= bus.mem_ready ? bus.mem_rdata : '0;
              end
            end
          end
          if (!bus.mem_ready) begin
            r_wait <= w_wait_inc;
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_byte    = r_mem_byte;
  assign bus.mem_double  = r_mem_double;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.if_rdata    = r_if_rdata;
  assign bus.if_ack      = r_if_ack;
  assign bus.dm_rdata    = r_dm_rdata;
  assign bus.dm_ack      = r_dm_ack;
  assign bus.err_timeout = r_err_timeout;
  assign bus.if_stall    = bus.if_req & ~r_if_ack;
  assign bus.dm_stall    = bus.dm_req & ~r_dm_ack;

endmodule
`default_nettype wire
